// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event strobes into LED flashes of HOLD_CYCLES high
// followed by GAP_CYCLES low, queueing events that arrive mid-flash.
module pulse_stretcher #(
    parameter int HOLD_CYCLES = 50000000,
    parameter int GAP_CYCLES  = 25000000,
    parameter int PEND_MAX    = 15,
    parameter int PEND_W      = 4
) (
    input  logic              clk,
    input  logic              clear_in,
    input  logic              pulse_in,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TIMER_W = $clog2(MAX_CYC + 1);

    localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
    localparam logic [PEND_W-1:0]  PEND_LIM  = PEND_W'(PEND_MAX);
    localparam logic [PEND_W-1:0]  PEND_ONE  = PEND_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [PEND_W-1:0]   pending_q, pending_d;
    logic                overflow_q, overflow_d;
    logic                led_q, led_d;
    logic                busy_q, busy_d;

    // The timer holds "cycles left minus one", so each state lasts load+1 edges.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (pulse_in) begin
                    state_d = HOLD;
                    timer_d = HOLD_LOAD;
                end
            end

            HOLD: begin
                if (timer_q == '0) begin
                    state_d = GAP;
                    timer_d = GAP_LOAD;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
                if (pulse_in) begin
                    if (pending_q < PEND_LIM) begin
                        pending_d = pending_q + PEND_ONE;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end

            GAP: begin
                if (timer_q == '0) begin
                    // A new strobe here replaces the dequeued slot rather than queueing.
                    if (pending_q != '0) begin
                        state_d = HOLD;
                        timer_d = HOLD_LOAD;
                        if (!pulse_in) begin
                            pending_d = pending_q - PEND_ONE;
                        end
                    end else if (pulse_in) begin
                        state_d = HOLD;
                        timer_d = HOLD_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                    if (pulse_in) begin
                        if (pending_q < PEND_LIM) begin
                            pending_d = pending_q + PEND_ONE;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        led_d  = (state_d == HOLD);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge clear_in) begin
        if (clear_in) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            led_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
        end
    end

    assign led_out  = led_q;
    assign busy     = busy_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: directed scenarios followed by a
// random strobe stream, compared each cycle against a flash-position model.
module tb_pulse_stretcher;

    localparam int H   = 4;
    localparam int G   = 2;
    localparam int MAX = 3;
    localparam int W   = 2;

    logic         clk;
    logic         clear_in;
    logic         pulse_in;
    logic         led_out;
    logic         busy;
    logic [W-1:0] pending;
    logic         overflow;

    int total;
    int bad;
    int flashes;
    logic prev_led;

    // Reference model: one flash is a window of H+G cycles, position m_pos.
    bit m_active;
    int m_pos;
    int m_pend;
    bit m_ovf;

    pulse_stretcher #(
        .HOLD_CYCLES(H),
        .GAP_CYCLES (G),
        .PEND_MAX   (MAX),
        .PEND_W     (W)
    ) dut (
        .clk     (clk),
        .clear_in(clear_in),
        .pulse_in(pulse_in),
        .led_out (led_out),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        m_active = 1'b0;
        m_pos    = 0;
        m_pend   = 0;
        m_ovf    = 1'b0;
    endtask

    task automatic modelEdge(input bit p);
        if (!m_active) begin
            if (p) begin
                m_active = 1'b1;
                m_pos    = 0;
            end
        end else if (m_pos == H + G - 1) begin
            if (m_pend > 0 || p) begin
                m_pos = 0;
                if (m_pend > 0 && !p) m_pend--;
            end else begin
                m_active = 1'b0;
            end
        end else begin
            m_pos++;
            if (p) begin
                if (m_pend < MAX) m_pend++;
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic         e_led;
        logic         e_busy;
        logic [W-1:0] e_pend;
        logic         e_ovf;
        e_led  = m_active && (m_pos < H);
        e_busy = m_active;
        e_pend = W'(m_pend);
        e_ovf  = m_ovf;
        total++;
        assert (led_out === e_led) else begin
            bad++;
            $error("[TB] FAIL %s led_out got=%b exp=%b", tag, led_out, e_led);
        end
        total++;
        assert (busy === e_busy) else begin
            bad++;
            $error("[TB] FAIL %s busy got=%b exp=%b", tag, busy, e_busy);
        end
        total++;
        assert (pending === e_pend) else begin
            bad++;
            $error("[TB] FAIL %s pending got=%0d exp=%0d", tag, pending, e_pend);
        end
        total++;
        assert (overflow === e_ovf) else begin
            bad++;
            $error("[TB] FAIL %s overflow got=%b exp=%b", tag, overflow, e_ovf);
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic applyStimulus(input bit p, input string tag);
        pulse_in = p;
        @(posedge clk);
        modelEdge(p);
        #1;
        pulse_in = 1'b0;
        checkOutput(tag);
        if (led_out === 1'b1 && prev_led !== 1'b1) flashes++;
        prev_led = led_out;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic resetPulse(input string tag);
        #2;
        clear_in = 1'b1;
        #1;
        modelReset();
        checkOutput(tag);
        @(posedge clk);
        #1;
        checkOutput(tag);
        clear_in = 1'b0;
        prev_led = 1'b0;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        flashes  = 0;
        prev_led = 1'b0;
        clear_in = 1'b1;
        pulse_in = 1'b0;
        modelReset();

        @(posedge clk);
        #1;
        resetPulse("reset");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, "reset_idle");

        applyStimulus(1'b1, "single");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, "single");

        applyStimulus(1'b1, "queued");
        applyStimulus(1'b1, "queued");
        applyStimulus(1'b1, "queued");
        for (int i = 0; i < 22; i++) applyStimulus(1'b0, "queued");

        flashes = 0;
        applyStimulus(1'b1, "ovf");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, "ovf");
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, "ovf");
        total++;
        assert (flashes === 4) else begin
            bad++;
            $error("[TB] FAIL ovf_flash_count got=%0d exp=%0d", flashes, 4);
        end

        resetPulse("ovf_clear");

        applyStimulus(1'b1, "boundary");
        applyStimulus(1'b1, "boundary");
        for (int i = 0; i < H + G - 2; i++) applyStimulus(1'b0, "boundary");
        applyStimulus(1'b1, "boundary_last_gap");
        total++;
        assert (pending === 2'd1 && led_out === 1'b1) else begin
            bad++;
            $error("[TB] FAIL boundary_restart pending=%0d led=%b exp pending=1 led=1",
                   pending, led_out);
        end
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, "boundary");

        applyStimulus(1'b1, "midreset");
        applyStimulus(1'b1, "midreset");
        applyStimulus(1'b1, "midreset");
        resetPulse("midreset_clear");
        applyStimulus(1'b1, "after_reset");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, "after_reset");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                resetPulse("rand_reset");
            end else begin
                applyStimulus($urandom_range(0, 9) < 3, "random");
            end
        end
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, "drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
